// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side sync controller: hunts the bit stream for COMMA, locks byte
// alignment after LOCK_CNT aligned commas, and drops lock on a stuck line.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       resync,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       byte_valid,
  output logic       active,
  output logic       idle_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_W   = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_W   = 4'(LOSS_CNT);
  localparam bit         LOCK_ONE = (LOCK_CNT == 1);

  state_t     state_q, state_next;
  // Only the last 7 samples are kept; the 8th window bit is serial_in itself.
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_next;
  logic [3:0] comma_cnt_q, comma_cnt_next;
  logic [3:0] loss_cnt_q, loss_cnt_next;
  logic [7:0] byte_out_q, byte_out_next;
  logic       strobe_q, strobe_next;
  logic       valid_q, valid_next;
  logic       active_q, active_next;

  logic [7:0] window;
  logic       boundary;
  logic       win_comma;
  logic       win_stuck;
  logic [3:0] comma_inc;
  logic [3:0] loss_inc;

  assign window    = {sr_q, serial_in};
  assign boundary  = (bit_cnt_q == 3'd7);
  assign win_comma = (window == COMMA);
  assign win_stuck = (window == 8'h00) || (window == 8'hFF);
  assign comma_inc = (comma_cnt_q == 4'hF) ? comma_cnt_q : comma_cnt_q + 4'd1;
  assign loss_inc  = (loss_cnt_q == 4'hF) ? loss_cnt_q : loss_cnt_q + 4'd1;

  // Output contract: byte_strobe is a one-cycle pulse per locked byte
  // boundary; byte_out is meaningful only while byte_strobe is high, and
  // byte_valid qualifies it as data (not a comma). No backpressure exists.
  always_comb begin
    state_next     = state_q;
    bit_cnt_next   = bit_cnt_q + 3'd1;
    comma_cnt_next = comma_cnt_q;
    loss_cnt_next  = loss_cnt_q;
    byte_out_next  = byte_out_q;
    strobe_next    = 1'b0;
    valid_next     = 1'b0;

    if (resync) begin
      state_next     = ST_SEARCH;
      bit_cnt_next   = 3'd0;
      comma_cnt_next = 4'd0;
      loss_cnt_next  = 4'd0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          bit_cnt_next  = 3'd0;
          loss_cnt_next = 4'd0;
          if (win_comma) begin
            comma_cnt_next = 4'd1;
            state_next     = LOCK_ONE ? ST_ACTIVE : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            if (win_comma) begin
              comma_cnt_next = comma_inc;
              if (comma_inc == LOCK_W) state_next = ST_ACTIVE;
            end else begin
              comma_cnt_next = 4'd0;
              state_next     = ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          if (boundary) begin
            if (win_stuck && (loss_inc == LOSS_W)) begin
              state_next     = ST_SEARCH;
              loss_cnt_next  = 4'd0;
              comma_cnt_next = 4'd0;
            end else begin
              loss_cnt_next = win_stuck ? loss_inc : 4'd0;
              byte_out_next = window;
              strobe_next   = 1'b1;
              valid_next    = !win_comma;
            end
          end
        end
        default: begin
          state_next     = ST_SEARCH;
          bit_cnt_next   = 3'd0;
          comma_cnt_next = 4'd0;
          loss_cnt_next  = 4'd0;
        end
      endcase
    end

    active_next = (state_next == ST_ACTIVE);
  end

  always_ff @(posedge clk_32f or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      sr_q        <= 7'd0;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      loss_cnt_q  <= 4'd0;
      byte_out_q  <= 8'd0;
      strobe_q    <= 1'b0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_next;
      sr_q        <= window[6:0];
      bit_cnt_q   <= bit_cnt_next;
      comma_cnt_q <= comma_cnt_next;
      loss_cnt_q  <= loss_cnt_next;
      byte_out_q  <= byte_out_next;
      strobe_q    <= strobe_next;
      valid_q     <= valid_next;
      active_q    <= active_next;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_strobe = strobe_q;
  assign byte_valid  = valid_q;
  assign active      = active_q;
  assign idle_out    = ~active_q;
  assign state       = state_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: serial stimulus driver plus a strobe
// monitor that checks each received byte against an expected queue.
module tb_phy_rx_sync_ctrl;

  logic       clk_32f;
  logic       rst;
  logic       serial_in;
  logic       resync;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       byte_valid;
  logic       active;
  logic       idle_out;
  logic [1:0] state;

  logic [8:0] exp_q[$];
  int         checks;
  int         errors;
  int         cyc;
  int         strobe_seen;
  int         last_strobe_cyc;
  int         prev_strobe_cyc;

  phy_rx_sync_ctrl dut (
    .clk_32f     (clk_32f),
    .rst         (rst),
    .serial_in   (serial_in),
    .resync      (resync),
    .byte_out    (byte_out),
    .byte_strobe (byte_strobe),
    .byte_valid  (byte_valid),
    .active      (active),
    .idle_out    (idle_out),
    .state       (state)
  );

  // clock / reset
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  always @(posedge clk_32f) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every strobe must match the head of exp_q
  always @(negedge clk_32f) begin
    if (!rst && byte_strobe) begin
      strobe_seen++;
      checks++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe actual valid=%0b byte=%02h required no strobe",
                 byte_valid, byte_out);
      end else begin
        logic [8:0] exp;
        exp = exp_q.pop_front();
        if ({byte_valid, byte_out} !== exp) begin
          errors++;
          $display("FAIL rx_byte actual valid=%0b byte=%02h required valid=%0b byte=%02h",
                   byte_valid, byte_out, exp[8], exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst       = 1'b1;
    serial_in = 1'b0;
    resync    = 1'b0;
    repeat (2) @(negedge clk_32f);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs_last);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_32f);
      serial_in = b[i];
      if (i == 0 && rs_last) resync = 1'b1;
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({(b != 8'hBC), b});
  endtask

  task automatic lock_link(input string tag);
    for (int k = 0; k < 4; k++) send_byte(8'hBC, 1'b0);
    check({tag, "_active_before"}, {31'd0, active}, 32'd0);
    @(posedge clk_32f);
    #1;
    check({tag, "_active_after"}, {31'd0, active}, 32'd1);
    check({tag, "_state_active"}, {30'd0, state}, 32'd2);
  endtask

  initial begin
    logic [2:0] offset;
    checks = 0;
    errors = 0;
    cyc = 0;
    strobe_seen = 0;
    last_strobe_cyc = 0;
    prev_strobe_cyc = 0;
    rst = 1'b1;
    serial_in = 1'b0;
    resync = 1'b0;
    #2;
    check("reset_byte_out", {24'd0, byte_out}, 32'd0);
    check("reset_strobe", {31'd0, byte_strobe}, 32'd0);
    check("reset_valid", {31'd0, byte_valid}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    check("reset_idle", {31'd0, idle_out}, 32'd1);
    check("reset_state", {30'd0, state}, 32'd0);

    // idle line: no lock, no strobes
    do_reset();
    repeat (40) @(negedge clk_32f);
    check("idle_state", {30'd0, state}, 32'd0);
    check("idle_active", {31'd0, active}, 32'd0);
    check("idle_idle_out", {31'd0, idle_out}, 32'd1);
    check("idle_no_strobe", strobe_seen, 32'd0);

    // lock after a 3-bit offset, then two data bytes 8 cycles apart
    do_reset();
    offset = 3'b010;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk_32f);
      serial_in = offset[i];
    end
    lock_link("lock");
    expect_byte(8'h55);
    send_byte(8'h55, 1'b0);
    expect_byte(8'hA3);
    send_byte(8'hA3, 1'b0);
    @(negedge clk_32f);
    #1;
    check("lock_strobe_spacing", last_strobe_cyc - prev_strobe_cyc, 32'd8);
    check("lock_idle_out", {31'd0, idle_out}, 32'd0);

    // failed alignment, then a good comma run
    do_reset();
    send_byte(8'hBC, 1'b0);
    send_byte(8'hBC, 1'b0);
    check("align_state_before_bad", {30'd0, state}, 32'd1);
    send_byte(8'h12, 1'b0);
    @(posedge clk_32f);
    #1;
    check("align_back_to_search", {30'd0, state}, 32'd0);
    lock_link("relock");
    expect_byte(8'h77);
    send_byte(8'h77, 1'b0);
    repeat (2) @(negedge clk_32f);

    // mid-lock comma is strobed but not valid
    do_reset();
    lock_link("midc");
    expect_byte(8'h10);
    send_byte(8'h10, 1'b0);
    expect_byte(8'hBC);
    send_byte(8'hBC, 1'b0);
    expect_byte(8'h20);
    send_byte(8'h20, 1'b0);
    repeat (2) @(negedge clk_32f);

    // loss of sync on stuck bytes, interrupted once by 0x44
    do_reset();
    lock_link("loss");
    for (int k = 0; k < 3; k++) begin
      expect_byte(8'h00);
      send_byte(8'h00, 1'b0);
    end
    expect_byte(8'h44);
    send_byte(8'h44, 1'b0);
    for (int k = 0; k < 3; k++) begin
      expect_byte(8'hFF);
      send_byte(8'hFF, 1'b0);
    end
    check("loss_held_active", {31'd0, active}, 32'd1);
    send_byte(8'hFF, 1'b0);
    @(posedge clk_32f);
    #1;
    check("loss_active", {31'd0, active}, 32'd0);
    check("loss_state", {30'd0, state}, 32'd0);
    check("loss_idle_out", {31'd0, idle_out}, 32'd1);
    check("loss_no_strobe", {31'd0, byte_strobe}, 32'd0);

    // resync coincident with a boundary
    do_reset();
    lock_link("rsync");
    send_byte(8'h33, 1'b1);
    @(posedge clk_32f);
    #1;
    check("resync_state", {30'd0, state}, 32'd0);
    check("resync_no_strobe", {31'd0, byte_strobe}, 32'd0);
    check("resync_active", {31'd0, active}, 32'd0);
    @(negedge clk_32f);
    resync = 1'b0;

    // relock without reset, then asynchronous reset between edges
    lock_link("arst");
    expect_byte(8'h66);
    send_byte(8'h66, 1'b0);
    @(posedge clk_32f);
    @(negedge clk_32f);
    @(posedge clk_32f);
    #3;
    rst = 1'b1;
    #1;
    check("arst_byte_out", {24'd0, byte_out}, 32'd0);
    check("arst_strobe", {31'd0, byte_strobe}, 32'd0);
    check("arst_valid", {31'd0, byte_valid}, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    check("arst_idle", {31'd0, idle_out}, 32'd1);
    check("arst_state", {30'd0, state}, 32'd0);
    @(negedge clk_32f);
    rst = 1'b0;
    repeat (4) @(negedge clk_32f);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
